// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - multicycle MIPS control FSM (optional jal/jr via MC_JAL_JR_EN)
module mips_multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic [5:0] Func,
  input  logic       Zero,
  output logic       PCLoad,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluOperation,
  output logic [1:0] PCSrc,
  output logic       Illegal,
  output logic       InstrDone
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
`ifdef MC_JAL_JR_EN
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
`endif
    S_JUMP      = 4'd11
  } state_t;

  state_t r_state;
  // Remembers lw vs sw from DECODE so MEM_ADDR does not depend on OpCode.
  logic   r_is_lw;

  state_t w_dec_next;
  logic   w_dec_illegal;
  logic   w_func_alu_ok;

  // Maps an R-type Func to its ALU operation code.
  function automatic logic [2:0] f_func_alu(input logic [5:0] f);
    case (f)
      FN_ADD:  f_func_alu = ALU_ADD;
      FN_SUB:  f_func_alu = ALU_SUB;
      FN_AND:  f_func_alu = ALU_AND;
      FN_OR:   f_func_alu = ALU_OR;
      FN_SLT:  f_func_alu = ALU_SLT;
      default: f_func_alu = ALU_ADD;
    endcase
  endfunction

  // Classifies the instruction in DECODE: next state plus illegal flag.
  always_comb begin
    w_func_alu_ok = (Func == FN_ADD) || (Func == FN_SUB) || (Func == FN_AND) ||
                    (Func == FN_OR)  || (Func == FN_SLT);
    w_dec_next    = S_FETCH;
    w_dec_illegal = 1'b0;
    case (OpCode)
      OP_RTYPE: begin
`ifdef MC_JAL_JR_EN
        if (Func == FN_JR) begin
          w_dec_next = S_JR;
        end else
`endif
        if (w_func_alu_ok) begin
          w_dec_next = S_R_EXEC;
        end else begin
          w_dec_illegal = 1'b1;
        end
      end
      OP_LW, OP_SW:    w_dec_next = S_MEM_ADDR;
      OP_BEQ:          w_dec_next = S_BRANCH;
      OP_ADDI, OP_SLTI: w_dec_next = S_I_EXEC;
      OP_J:            w_dec_next = S_JUMP;
`ifdef MC_JAL_JR_EN
      OP_JAL:          w_dec_next = S_JAL;
`endif
      default:         w_dec_illegal = 1'b1;
    endcase
  end

  // State register: reset lands in FETCH, every terminal state returns to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_is_lw <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:     r_state <= S_DECODE;
        S_DECODE: begin
          r_state <= w_dec_next;
          r_is_lw <= (OpCode == OP_LW);
        end
        S_MEM_ADDR:  r_state <= r_is_lw ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  r_state <= S_MEM_WB;
        S_R_EXEC:    r_state <= S_R_WB;
        S_I_EXEC:    r_state <= S_I_WB;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  // Output decode from state; everything held low while reset is asserted.
  always_comb begin
    PCLoad       = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 2'b00;
    MemToReg     = 2'b00;
    RegWrite     = 1'b0;
    AluSrcA      = 1'b0;
    AluSrcB      = 2'b00;
    AluOperation = 3'b000;
    PCSrc        = 2'b00;
    Illegal      = 1'b0;
    InstrDone    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          MemRead      = 1'b1;
          IRWrite      = 1'b1;
          AluSrcB      = 2'b01;
          AluOperation = ALU_ADD;
          PCSrc        = 2'b00;
          PCLoad       = 1'b1;
        end
        S_DECODE: begin
          AluSrcB      = 2'b11;
          AluOperation = ALU_ADD;
          Illegal      = w_dec_illegal;
          InstrDone    = w_dec_illegal;
        end
        S_MEM_ADDR: begin
          AluSrcA      = 1'b1;
          AluSrcB      = 2'b10;
          AluOperation = ALU_ADD;
        end
        S_MEM_READ: begin
          IorD         = 1'b1;
          MemRead      = 1'b1;
        end
        S_MEM_WB: begin
          MemToReg     = 2'b01;
          RegWrite     = 1'b1;
          InstrDone    = 1'b1;
        end
        S_MEM_WRITE: begin
          IorD         = 1'b1;
          MemWrite     = 1'b1;
          InstrDone    = 1'b1;
        end
        S_R_EXEC: begin
          AluSrcA      = 1'b1;
          AluSrcB      = 2'b00;
          AluOperation = f_func_alu(Func);
        end
        S_R_WB: begin
          RegDst       = 2'b01;
          RegWrite     = 1'b1;
          InstrDone    = 1'b1;
        end
        S_I_EXEC: begin
          AluSrcA      = 1'b1;
          AluSrcB      = 2'b10;
          AluOperation = (OpCode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_I_WB: begin
          RegWrite     = 1'b1;
          InstrDone    = 1'b1;
        end
        S_BRANCH: begin
          AluSrcA      = 1'b1;
          AluSrcB      = 2'b00;
          AluOperation = ALU_SUB;
          PCSrc        = 2'b01;
          PCLoad       = Zero;
          InstrDone    = 1'b1;
        end
        S_JUMP: begin
          PCSrc        = 2'b10;
          PCLoad       = 1'b1;
          InstrDone    = 1'b1;
        end
`ifdef MC_JAL_JR_EN
        S_JAL: begin
          RegDst       = 2'b10;
          MemToReg     = 2'b10;
          RegWrite     = 1'b1;
          PCSrc        = 2'b10;
          PCLoad       = 1'b1;
          InstrDone    = 1'b1;
        end
        S_JR: begin
          PCSrc        = 2'b11;
          PCLoad       = 1'b1;
          InstrDone    = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb/tb_mips_multicycle_controller.sv - randomized self-checking bench for the multicycle controller
`timescale 1ns/1ps
module tb_mips_multicycle_controller;

  typedef struct packed {
    logic       pcload;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       illegal;
    logic       instrdone;
  } ctl_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_SLTI = 5;
  localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] OpCode = 6'd0;
  logic [5:0] Func = 6'd0;
  logic       Zero = 1'b0;
  logic       PCLoad, IorD, MemRead, MemWrite, IRWrite, RegWrite, AluSrcA, Illegal, InstrDone;
  logic [1:0] RegDst, MemToReg, AluSrcB, PCSrc;
  logic [2:0] AluOperation;
  ctl_t       obs;

  int total = 0;
  int bad = 0;

  assign obs = {PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
                AluSrcA, AluSrcB, AluOperation, PCSrc, Illegal, InstrDone};

  always #5 clk = ~clk;

  mips_multicycle_controller dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Func(Func), .Zero(Zero),
    .PCLoad(PCLoad), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOperation(AluOperation),
    .PCSrc(PCSrc), .Illegal(Illegal), .InstrDone(InstrDone)
  );

  // Instruction class from the ISA encoding.
  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    int k;
    k = K_ILL;
    case (op)
      6'b000000: begin
        if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
            fn == 6'b100101 || fn == 6'b101010) k = K_R;
`ifdef MC_JAL_JR_EN
        else if (fn == 6'b001000) k = K_JR;
`endif
      end
      6'b100011: k = K_LW;
      6'b101011: k = K_SW;
      6'b000100: k = K_BEQ;
      6'b001000: k = K_ADDI;
      6'b001010: k = K_SLTI;
      6'b000010: k = K_J;
`ifdef MC_JAL_JR_EN
      6'b000011: k = K_JAL;
`endif
      default:   k = K_ILL;
    endcase
    return k;
  endfunction

  // Clock count of each instruction class, FETCH included.
  function automatic int latency(input int kind);
    int n;
    n = 3;
    if (kind == K_LW) n = 5;
    else if (kind == K_SW || kind == K_R || kind == K_ADDI || kind == K_SLTI) n = 4;
    else if (kind == K_ILL) n = 2;
    return n;
  endfunction

  function automatic ctl_t fetch_vec();
    ctl_t e;
    e = '0; e.memread = 1; e.irwrite = 1; e.alusrcb = 2'b01; e.aluop = 3'b010; e.pcload = 1;
    return e;
  endfunction

  // Expected control word for clock k of an instruction of the given class.
  function automatic ctl_t expect_vec(input int kind, input int k, input logic [5:0] fn,
                                      input logic z);
    ctl_t e;
    e = '0;
    if (k == 0) begin
      e = fetch_vec();
    end else if (k == 1) begin
      e.alusrcb = 2'b11; e.aluop = 3'b010;
      if (kind == K_ILL) begin e.illegal = 1; e.instrdone = 1; end
    end else begin
      case (kind)
        K_LW, K_SW: begin
          if (k == 2) begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 3'b010; end
          else if (kind == K_SW) begin e.iord = 1; e.memwrite = 1; e.instrdone = 1; end
          else if (k == 3) begin e.iord = 1; e.memread = 1; end
          else begin e.memtoreg = 2'b01; e.regwrite = 1; e.instrdone = 1; end
        end
        K_R: begin
          if (k == 2) begin
            e.alusrca = 1;
            case (fn)
              6'b100000: e.aluop = 3'b010;
              6'b100010: e.aluop = 3'b110;
              6'b100100: e.aluop = 3'b000;
              6'b100101: e.aluop = 3'b001;
              default:   e.aluop = 3'b111;
            endcase
          end else begin e.regdst = 2'b01; e.regwrite = 1; e.instrdone = 1; end
        end
        K_ADDI, K_SLTI: begin
          if (k == 2) begin
            e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = (kind == K_SLTI) ? 3'b111 : 3'b010;
          end else begin e.regwrite = 1; e.instrdone = 1; end
        end
        K_BEQ: begin
          e.alusrca = 1; e.aluop = 3'b110; e.pcsrc = 2'b01; e.pcload = z; e.instrdone = 1;
        end
        K_J:   begin e.pcsrc = 2'b10; e.pcload = 1; e.instrdone = 1; end
        K_JAL: begin
          e.regdst = 2'b10; e.memtoreg = 2'b10; e.regwrite = 1;
          e.pcsrc = 2'b10; e.pcload = 1; e.instrdone = 1;
        end
        K_JR:  begin e.pcsrc = 2'b11; e.pcload = 1; e.instrdone = 1; end
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  // Runs one instruction starting just after a rising edge in FETCH; OpCode/Func carry
  // random garbage in every clock where the controller must not be looking at them.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z);
    int   kind, n;
    ctl_t e;
    kind = classify(op, fn);
    n = latency(kind);
    for (int k = 0; k < n; k++) begin
      if (k == 1 || (k == 2 && (kind == K_R || kind == K_ADDI || kind == K_SLTI))) begin
        OpCode = op; Func = fn;
      end else begin
        OpCode = 6'($urandom); Func = 6'($urandom);
      end
      Zero = (kind == K_BEQ && k == 2) ? z : 1'($urandom);
      e = expect_vec(kind, k, fn, z);
      @(negedge clk);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s op=%b fn=%b clk%0d: got %h want %h", name, op, fn, k, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    ctl_t e;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_hold: got %h want 0", obs); end
    @(posedge clk); #1;
    rst = 1'b0;
    e = fetch_vec();
    @(negedge clk);
    total++;
    if (obs !== e) begin bad++; $display("FAIL reset_first_fetch: got %h want %h", obs, e); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_async_in_fetch: got %h want 0", obs); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lw();
    run_instr("lw", 6'b100011, 6'($urandom), 1'b0);
    run_instr("sw", 6'b101011, 6'($urandom), 1'b1);
  endtask

  task automatic test_rtype_sweep();
    logic [5:0] fns [5];
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b101010;
    for (int i = 0; i < 5; i++) run_instr("rtype", 6'b000000, fns[i], 1'($urandom));
    run_instr("addi", 6'b001000, 6'($urandom), 1'b0);
    run_instr("slti", 6'b001010, 6'($urandom), 1'b0);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'b000100, 6'($urandom), 1'b1);
    run_instr("beq_not_taken", 6'b000100, 6'($urandom), 1'b0);
    run_instr("j", 6'b000010, 6'($urandom), 1'b1);
  endtask

  task automatic test_jal_jr();
    run_instr("jal", 6'b000011, 6'($urandom), 1'b0);
    run_instr("jr", 6'b000000, 6'b001000, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", 6'b111111, 6'($urandom), 1'b1);
    run_instr("illegal_func", 6'b000000, 6'b000111, 1'b0);
  endtask

  task automatic test_abort();
    for (int k = 0; k < 3; k++) begin
      OpCode = 6'b101011; Func = 6'($urandom);
      if (k < 2) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    total++;
    if (AluSrcB !== 2'b10) begin bad++; $display("FAIL abort_mem_addr: got %b want 10", AluSrcB); end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL abort_async: got %h want 0", obs); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (MemWrite !== 1'b0 || RegWrite !== 1'b0 || PCLoad !== 1'b0) begin
        bad++;
        $display("FAIL abort_suppress: got mw=%b rw=%b pl=%b want 0", MemWrite, RegWrite, PCLoad);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr("after_abort", 6'b100011, 6'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [10];
    logic [5:0] op, fn;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b001010; ops[6] = 6'b000010; ops[7] = 6'b000011;
    ops[8] = 6'b000000; ops[9] = 6'b000000;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       op = 6'($urandom);
        default: op = ops[$urandom_range(0, 9)];
      endcase
      case ($urandom_range(0, 7))
        0:       fn = 6'b001000;
        1:       fn = 6'($urandom);
        2:       fn = 6'b100000;
        3:       fn = 6'b100010;
        4:       fn = 6'b100100;
        5:       fn = 6'b100101;
        default: fn = 6'b101010;
      endcase
      run_instr("random", op, fn, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_sweep();
    test_beq();
    test_jal_jr();
    test_illegal();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
